dmem_responder: RTL

Memory-side responder for the data-cache line interface: accepts 256-bit line read/write requests issued by the data cache (`mem_enable`/`mem_write`/`mem_addr`/`mem_data`), holds them for a fixed access latency, and completes each with a one-cycle `mem_ack`. It sits outside the CPU top, on the memory side of the cache's memory port. It replaces the behavioural data memory in the pipeline testbench and the FPGA build.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Holds the FSM state enum, line width and line-offset width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } dmem_state_t;

  localparam int DMEM_LINE_W      = 256;
  localparam int DMEM_OFFSET_BITS = 5;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port line storage, synchronous write, registered read.
// Ports: clk, rst_n (clears read register only), wr_en, rd_en, idx, wdata, rdata.
module dmem_array #(
  parameter int LINE_W      = 256,
  parameter int DEPTH_LINES = 512,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wdata;
    end
  end

  // Read register holds its value across writes and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency 256-bit line memory behind the dcache port.
// Ports: clk_i, rst_i (async, active-low), mem_enable_i, mem_write_i,
// mem_addr_i, mem_data_i, mem_data_o, mem_ack_o; err_o with DMEM_PROTOCOL_CHK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 512,
  parameter int LINE_W      = DMEM_LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_ack_o
`ifdef DMEM_PROTOCOL_CHK_EN
  ,
  output logic              err_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dmem_state_t       state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              accept;
  logic              ack_q;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] data_q;
  logic              arr_wr, arr_rd;

  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:DMEM_OFFSET_BITS+IDX_W],
                         mem_addr_i[DMEM_OFFSET_BITS-1:0]};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_enable_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - CNT_ONE;
        // Counter reaching zero on this edge hands off to ACK.
        if (cnt == CNT_ONE) begin
          state_d = ACK;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      ack_q  <= 1'b0;
      wr_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ack_q <= (state == ACK);
      if (accept) begin
        wr_q   <= mem_write_i;
        idx_q  <= mem_addr_i[DMEM_OFFSET_BITS +: IDX_W];
        data_q <= mem_data_i;
      end
    end
  end

  // Array access is issued from ACK so data and strobe land together.
  assign arr_wr    = (state == ACK) && wr_q;
  assign arr_rd    = (state == ACK) && !wr_q;
  assign mem_ack_o = ack_q;

  dmem_array #(
    .LINE_W      (LINE_W),
    .DEPTH_LINES (DEPTH_LINES)
  ) u_array (
    .clk   (clk_i),
    .rst_n (rst_i),
    .wr_en (arr_wr),
    .rd_en (arr_rd),
    .idx   (idx_q),
    .wdata (data_q),
    .rdata (mem_data_o)
  );

`ifdef DMEM_PROTOCOL_CHK_EN
  localparam int LA_W = 32 - DMEM_OFFSET_BITS;

  logic [LA_W-1:0] line_q;
  logic [LA_W-1:0] req_line;
  logic            bad_wait;
  logic            bad_range;
  logic            err_q;

  assign req_line  = mem_addr_i[31:DMEM_OFFSET_BITS];
  assign bad_wait  = (state == WAIT) && mem_enable_i &&
                     ((mem_write_i != wr_q) || (req_line != line_q));
  assign bad_range = accept && (req_line >= LA_W'(DEPTH_LINES));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      line_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        line_q <= req_line;
      end
      if (bad_wait || bad_range) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`endif

endmodule
